lane_packer: RTL and testbench
==============================

// Module: lane_packer
// PURPOSE
//   Serial-to-parallel packer: accepts one LANE_W-bit lane per valid/ready handshake,
//   builds a packed [LANES-1:0][LANE_W-1:0] word with the first lane in the LSBs, and
//   presents it on a registered valid/ready output. A 2x4 instance reproduces the {b,a} packing.
//   It sits between narrow producers and wide consumers and uses fill/output double-buffering.
// PARAMETERS
//   LANES   2  number of lanes per output word (>=2)
//   LANE_W  4  bits per lane (>=1)
// PORTS
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous reset, active-high
//   in_valid   in   1               input lane valid
//   in_ready   out  1               input lane accepted when in_valid && in_ready
//   in_data    in   LANE_W          lane payload
//   in_last    in   1               close the word early with this lane (remaining lanes zero)
//   out_valid  out  1               packed word valid
//   out_ready  in   1               consumer accepts when out_valid && out_ready
//   out_data   out  LANES*LANE_W    packed word; lane i at [i*LANE_W +: LANE_W]
//   out_count  out  $clog2(LANES+1) number of lanes filled in out_data (1..LANES)
// BEHAVIOUR
//   Reset (async, rst=1): state FILL, lane index 0, fill buffer 0, out_valid=0, out_data=0,
//     out_count=0. in_ready=0 while rst=1. An in-flight partial word is discarded.
//   Fill buffer: internal packed array fill[LANES-1:0][LANE_W-1:0] and index idx.
//   in_ready = (state==FILL) && !rst. It is a pure function of state and does not depend on in_valid or in_data.
//   FILL, accept (in_valid&&in_ready): fill[idx] <= in_data.
//     - not completing (idx<LANES-1 && !in_last): idx <= idx+1.
//     - completing (idx==LANES-1 || in_last): word = fill with lane idx set to in_data and
//       lanes above idx forced to 0; count = idx+1; idx <= 0; fill <= 0.
//       If the output slot is free (!out_valid || out_ready), load out_data/out_count and set
//       out_valid=1 on the next edge (1-cycle latency after the last accept). Stay in FILL.
//       Otherwise park the word in the fill buffer and go to FULL.
//   FULL: in_ready=0. On out_valid&&out_ready, move the parked word to the output next edge,
//     keep out_valid=1, clear the fill buffer, and return to FILL.
//   Output: out_valid clears on out_valid&&out_ready unless a new word loads in the same cycle
//     (back-to-back words give no bubble). out_data/out_count are stable while out_valid&&!out_ready.
//   in_last at idx==LANES-1 behaves the same as a normal completion.
//   Accepting a lane and consuming an output in the same cycle are both honoured.
//   Throughput: 1 lane/cycle sustained when out_ready=1. Max stall buffering is 1 word in
//     output plus 1 word in fill.
//   Width rules: idx width is $clog2(LANES), clamped to at least 1. out_count is zero-extended idx+1.
// TESTING (LANES=2, LANE_W=4 unless noted)
//   1. Lanes 0x3 then 0xA, out_ready=1 -> one cycle after 2nd accept out_data=0xA3, out_count=2.
//   2. Lane 0x5 with in_last=1 -> out_data=0x05, out_count=1. Next word starts at lane 0.
//   3. out_ready=0, feed 0x1,0x2,0x3,0x4 -> out=0x21 held, FULL after 0x4, in_ready=0;
//      raise out_ready -> 0x43 next cycle without a bubble, in_ready=1.
//   4. Continuous stream 0x0..0xF with out_ready=1 -> 8 words 0x10,0x32,..,0xFE, one every 2 cycles.
//   5. rst pulse mid-word (after 0x7) and while out_valid=1 -> all outputs 0 immediately.
//      Then 0x1,0x2 -> 0x21 (0x7 is lost).
//   6. LANES=4, LANE_W=8: 0x11,0x22,0x33,0x44 -> 0x44332211, out_count=4. Also 0xAA with
//      in_last -> 0x000000AA, out_count=1.

Source files
------------

// File: rtl/lane_packer.sv
// Serial-to-parallel lane packer with fill/output double buffering.
// Narrow lanes are accumulated LSB-first into a wide word that is presented on a registered valid/ready port.
module lane_packer #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANE_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*LANE_W-1:0]     out_data,
  output logic [$clog2(LANES+1)-1:0]  out_count
);

  localparam int unsigned IDX_W = (LANES > 2) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                         r_state;
  logic [IDX_W-1:0]               r_idx;
  logic [LANES-1:0][LANE_W-1:0]   r_fill;
  logic [CNT_W-1:0]               r_park_count;
  logic                           r_out_valid;
  logic [LANES*LANE_W-1:0]        r_out_data;
  logic [CNT_W-1:0]               r_out_count;

  logic                           w_accept;
  logic                           w_complete;
  logic                           w_out_free;
  logic                           w_out_take;
  logic [CNT_W-1:0]               w_count;
  logic [LANES-1:0][LANE_W-1:0]   w_word;

  assign in_ready   = (r_state == FILL) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = (r_idx == IDX_W'(LANES - 1)) || in_last;
  assign w_out_take = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;
  assign w_count    = CNT_W'(r_idx) + CNT_W'(1);

  // Completed word: lanes below idx from the fill buffer, the incoming lane at idx, zeros above
  always_comb begin
    w_word = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (IDX_W'(i) < r_idx) begin
        w_word[i] = r_fill[i];
      end else if (IDX_W'(i) == r_idx) begin
        w_word[i] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_idx        <= '0;
      r_fill       <= '0;
      r_park_count <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_count  <= '0;
    end else begin
      if (w_out_take) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (!w_complete) begin
              r_fill[r_idx] <= in_data;
              r_idx         <= r_idx + IDX_W'(1);
            end else begin
              r_idx <= '0;
              if (w_out_free) begin
                r_fill      <= '0;
                r_out_data  <= w_word;
                r_out_count <= w_count;
                r_out_valid <= 1'b1;
              end else begin
                // Output slot busy: the fill buffer holds the finished word until it drains
                r_fill       <= w_word;
                r_park_count <= w_count;
                r_state      <= FULL;
              end
            end
          end
        end
        FULL: begin
          if (w_out_take) begin
            r_out_data  <= r_fill;
            r_out_count <= r_park_count;
            r_out_valid <= 1'b1;
            r_fill      <= '0;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer: a 2x4 instance for packing/stall/reset behaviour
// and a 4x8 instance for the wide-word case.
module tb_lane_packer;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
  logic [3:0]  a_in_data;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_count;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data;
  logic [31:0] b_out_data;
  logic [2:0]  b_out_count;

  int n_pass  = 0;
  int n_total = 0;

  lane_packer #(.LANES(2), .LANE_W(4)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_count(a_out_count)
  );

  lane_packer #(.LANES(4), .LANE_W(8)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_count(b_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present one lane for exactly one rising edge, returning at the following falling edge
  task automatic send_a(input logic [3:0] d, input logic l);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = l;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_last  = l;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_out_data",  32'(a_out_data),  32'h0);
    chk("rst_out_count", 32'(a_out_count), 32'h0);
    chk("rst_in_ready",  32'(a_in_ready),  32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(a_in_ready), 32'h1);
    @(negedge clk);

    // Two full lanes, consumer ready
    a_out_ready = 1'b1;
    send_a(4'h3, 1'b0);
    chk("t1_no_early_valid", 32'(a_out_valid), 32'h0);
    send_a(4'hA, 1'b0);
    chk("t1_valid", 32'(a_out_valid), 32'h1);
    chk("t1_data",  32'(a_out_data),  32'hA3);
    chk("t1_count", 32'(a_out_count), 32'h2);
    @(negedge clk);
    chk("t1_drained", 32'(a_out_valid), 32'h0);

    // Early close with in_last, then next word starts at lane 0
    send_a(4'h5, 1'b1);
    chk("t2_valid", 32'(a_out_valid), 32'h1);
    chk("t2_data",  32'(a_out_data),  32'h05);
    chk("t2_count", 32'(a_out_count), 32'h1);
    send_a(4'h6, 1'b0);
    send_a(4'h7, 1'b0);
    chk("t2_next_data",  32'(a_out_data),  32'h76);
    chk("t2_next_count", 32'(a_out_count), 32'h2);
    @(negedge clk);
    chk("t2_drained", 32'(a_out_valid), 32'h0);

    // Stalled consumer: one word in output, one parked in fill
    a_out_ready = 1'b0;
    send_a(4'h1, 1'b0);
    send_a(4'h2, 1'b0);
    chk("t3_first_data", 32'(a_out_data), 32'h21);
    send_a(4'h3, 1'b0);
    send_a(4'h4, 1'b0);
    chk("t3_held_data",  32'(a_out_data),  32'h21);
    chk("t3_held_valid", 32'(a_out_valid), 32'h1);
    chk("t3_full_ready", 32'(a_in_ready),  32'h0);
    a_in_valid = 1'b1;
    a_in_data  = 4'hF;
    @(negedge clk);
    chk("t3_still_held", 32'(a_out_data), 32'h21);
    chk("t3_still_full", 32'(a_in_ready), 32'h0);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("t3_move_valid", 32'(a_out_valid), 32'h1);
    chk("t3_move_data",  32'(a_out_data),  32'h43);
    chk("t3_move_count", 32'(a_out_count), 32'h2);
    chk("t3_ready_back", 32'(a_in_ready),  32'h1);
    @(negedge clk);
    chk("t3_drained", 32'(a_out_valid), 32'h0);

    // Sustained stream: one word every two cycles
    for (int k = 0; k < 16; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 4'(k);
      @(negedge clk);
      chk($sformatf("t4_valid_%0d", k), 32'(a_out_valid), 32'(k % 2));
      if (k % 2 == 1)
        chk($sformatf("t4_data_%0d", k / 2), 32'(a_out_data), 32'({4'(k), 4'(k - 1)}));
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("t4_drained", 32'(a_out_valid), 32'h0);

    // Reset while a word is held and another is half built
    a_out_ready = 1'b0;
    send_a(4'h8, 1'b0);
    send_a(4'h9, 1'b0);
    send_a(4'h7, 1'b0);
    chk("t5_pre_valid", 32'(a_out_valid), 32'h1);
    chk("t5_pre_data",  32'(a_out_data),  32'h98);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(a_out_valid), 32'h0);
    chk("t5_rst_data",  32'(a_out_data),  32'h0);
    chk("t5_rst_count", 32'(a_out_count), 32'h0);
    chk("t5_rst_ready", 32'(a_in_ready),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    send_a(4'h1, 1'b0);
    send_a(4'h2, 1'b0);
    chk("t5_after_data",  32'(a_out_data),  32'h21);
    chk("t5_after_count", 32'(a_out_count), 32'h2);

    // Wide instance: full word and single-lane early close
    b_out_ready = 1'b1;
    send_b(8'h11, 1'b0);
    send_b(8'h22, 1'b0);
    send_b(8'h33, 1'b0);
    chk("t6_no_early_valid", 32'(b_out_valid), 32'h0);
    send_b(8'h44, 1'b0);
    chk("t6_valid", 32'(b_out_valid), 32'h1);
    chk("t6_data",  b_out_data,       32'h44332211);
    chk("t6_count", 32'(b_out_count), 32'h4);
    send_b(8'hAA, 1'b1);
    chk("t6_last_valid", 32'(b_out_valid), 32'h1);
    chk("t6_last_data",  b_out_data,       32'h000000AA);
    chk("t6_last_count", 32'(b_out_count), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
